low_pulse_gen: RTL and testbench



---
 rtl/low_pulse_gen_pkg.sv | 22 ++
 rtl/low_pulse_gen_pulse_req_buf.sv | 55 +++++
 rtl/low_pulse_gen.sv | 116 +++++++++++
 tb/tb_low_pulse_gen.sv | 130 +++++++++++++
 4 files changed

// File: rtl/low_pulse_gen_pkg.sv
// Shared types and constants for the active-low pulse generator.
// Includes the receiver filter threshold that the low width must exceed.
package low_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int LOW_MIN_DEF  = 4;
  localparam int HIGH_MIN_DEF = 4;
  localparam int RX_THRESH    = 3;

  function automatic int max_int(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/low_pulse_gen_pulse_req_buf.sv
// One-entry pending request buffer with overflow strobe.
// On drain with a stored entry, a same-cycle request refills the slot.
module pulse_req_buf
  import low_pulse_gen_pkg::*;
#(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [LW-1:0] eff_in,
  input  logic          drain,
  output logic          valid,
  output logic          valid_next,
  output logic [LW-1:0] eff,
  output logic          ovf
);

  logic          take;
  logic [LW-1:0] eff_n;
  logic          ovf_n;

  // An empty buffer at drain time lets the FSM consume the request directly.
  assign take = req && !(drain && !valid);

  always_comb begin
    valid_next = valid;
    eff_n      = eff;
    ovf_n      = 1'b0;
    if (drain && valid) begin
      valid_next = take;
      if (take) eff_n = eff_in;
    end else if (take) begin
      if (valid) begin
        ovf_n = 1'b1;
      end else begin
        valid_next = 1'b1;
        eff_n      = eff_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      eff   <= '0;
      ovf   <= 1'b0;
    end else begin
      valid <= valid_next;
      eff   <= eff_n;
      ovf   <= ovf_n;
    end
  end

endmodule

// File: rtl/low_pulse_gen.sv
// Turns single-cycle triggers into active-low pulses with
// guaranteed minimum low width and minimum high recovery gap.
module low_pulse_gen
  import low_pulse_gen_pkg::*;
#(
  parameter int LOW_MIN  = LOW_MIN_DEF,
  parameter int HIGH_MIN = HIGH_MIN_DEF,
  parameter int LW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trig,
  input  logic [LW-1:0] len,
  output logic          out,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  localparam int CW = max_int(LW, $clog2(HIGH_MIN));

  generate
    if (LOW_MIN <= RX_THRESH || LOW_MIN > 15 ||
        LOW_MIN > (2 ** LW) - 1) begin : g_bad_low_min
      $error("LOW_MIN out of range for receiver threshold or LW");
    end
    if (HIGH_MIN < 1 || HIGH_MIN > 15) begin : g_bad_high_min
      $error("HIGH_MIN out of range");
    end
  endgenerate

  state_t        state_q;
  state_t        state_n;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_n;
  logic [LW-1:0] eff;
  logic          active;
  logic          last_gap;
  logic          pend_valid;
  logic          pend_valid_n;
  logic [LW-1:0] pend_eff;

  assign eff      = (len < LW'(LOW_MIN)) ? LW'(LOW_MIN) : len;
  assign active   = (state_q != ST_IDLE);
  assign last_gap = (state_q == ST_GAP) && (cnt_q == '0);

  pulse_req_buf #(
    .LW(LW)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (trig && active),
    .eff_in     (eff),
    .drain      (last_gap),
    .valid      (pend_valid),
    .valid_next (pend_valid_n),
    .eff        (pend_eff),
    .ovf        (ovf)
  );

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_n = ST_LOW;
          cnt_n   = CW'(eff) - CW'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          state_n = ST_GAP;
          cnt_n   = CW'(HIGH_MIN - 1);
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CW'(1);
        end else if (pend_valid) begin
          state_n = ST_LOW;
          cnt_n   = CW'(pend_eff) - CW'(1);
        end else if (trig) begin
          state_n = ST_LOW;
          cnt_n   = CW'(eff) - CW'(1);
        end else begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out     <= 1'b1;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      out     <= (state_n != ST_LOW);
      done    <= (state_q == ST_LOW) && (cnt_q == '0);
      busy    <= (state_n != ST_IDLE) || pend_valid_n;
    end
  end

endmodule

// File: tb/tb_low_pulse_gen.sv
// Directed bench: per-cycle expected traces queued, then popped and checked.
// Outputs are sampled on the falling edge; inputs change right after.
module tb_low_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0;
  logic [3:0] len = '0;
  logic       out;
  logic       busy;
  logic       done;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  low_pulse_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (trig),
    .len   (len),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  function automatic string rep(input string c, input int n);
    string s;
    s = "";
    for (int k = 0; k < n; k++) s = {s, c};
    return s;
  endfunction

  function automatic logic [3:0] hexv(input byte c);
    if (c >= "a") return 4'(c - "a" + 10);
    return 4'(c - "0");
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got out/busy/done/ovf=%b want %b", tag, obs, exp);
    end
  endtask

  // Column i of each trace is what cycle i shows; tr/ln drive that cycle.
  task automatic run(input string name, input string tr, input string ln,
                     input string eo, input string eb, input string ed,
                     input string ev);
    logic [3:0] exp;
    int n;
    n = tr.len();
    for (int i = 0; i < n; i++)
      sb.push_back({eo[i] == "1", eb[i] == "1",
                    ed[i] == "1", ev[i] == "1"});
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp = sb.pop_front();
      chk($sformatf("%s[%0d]", name, i), {out, busy, done, ovf}, exp);
      trig = (tr[i] == "1");
      len  = hexv(ln[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    trig  = 1'b1;
    len   = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset[%0d]", i), {out, busy, done, ovf}, 4'b1000);
    end
    trig  = 1'b0;
    rst_n = 1'b1;

    run("idle", rep("0", 10), rep("0", 10), rep("1", 10),
        rep("0", 10), rep("0", 10), rep("0", 10));

    run("single", {"1", rep("0", 10)}, rep("0", 11),
        "10000111111", "01111111100", "00000100000", rep("0", 11));

    run("len9", {"1", rep("0", 15)}, {"9", rep("0", 15)},
        {"1", rep("0", 9), rep("1", 6)},
        {"0", rep("1", 13), "00"},
        {rep("0", 10), "1", rep("0", 5)}, rep("0", 16));

    run("len2", {"1", rep("0", 10)}, {"2", rep("0", 10)},
        "10000111111", "01111111100", "00000100000", rep("0", 11));

    run("ovf", {"1011", rep("0", 18)}, {"5067", rep("0", 18)},
        {"1", rep("0", 5), rep("1", 4), rep("0", 6), rep("1", 6)},
        {"0", rep("1", 19), "00"},
        {rep("0", 6), "1", rep("0", 9), "1", rep("0", 5)},
        {rep("0", 4), "1", rep("0", 17)});

    run("b2b", {"100000001", rep("0", 10)}, rep("0", 19),
        {"1", rep("0", 4), rep("1", 4), rep("0", 4), rep("1", 6)},
        {"0", rep("1", 16), "00"},
        {rep("0", 5), "1", rep("0", 7), "1", rep("0", 5)},
        rep("0", 19));

    run("refill", {"101000001", rep("0", 21)},
        {"405000006", rep("0", 21)},
        {"1", rep("0", 4), rep("1", 4), rep("0", 5), rep("1", 4),
         rep("0", 6), rep("1", 6)},
        {"0", rep("1", 27), "00"},
        {rep("0", 5), "1", rep("0", 8), "1", rep("0", 9), "1",
         rep("0", 5)},
        rep("0", 30));

    run("midlow", "110", "000", "100", "011", "000", "000");
    #1 rst_n = 1'b0;
    #1 chk("rst_async", {out, busy, done, ovf}, 4'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    trig  = 1'b0;
    run("post_rst", rep("0", 12), rep("0", 12), rep("1", 12),
        rep("0", 12), rep("0", 12), rep("0", 12));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
